// File: rtl/mem_access_if.sv
// Byte-serial data-memory bus between the bf8b memory-access stage (master)
// and data memory (slave).
// Handshake: a byte moves on a rising clk edge where mem_req and mem_ack are both high.
// The master holds mem_addr/mem_wdata/mem_we stable until that edge, and mem_ack without mem_req has no effect.
interface mem_access_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic [7:0]            mem_rdata;
    logic                  mem_we;
    logic                  mem_req;
    logic                  mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_req,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_req,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access.sv
// bf8b memory-access stage: loads/stores become little-endian byte-serial bus
// transactions, other ops pass the ALU result through; one wb_en pulse per instruction.
module mem_access #(
    parameter int         M_WIDTH        = 32,
    parameter int         ADDR_WIDTH     = 32,
    parameter int         REG_ADDR_WIDTH = 4,
    parameter logic [6:0] OP_LOAD        = 7'b0000011,
    parameter logic [6:0] OP_STORE       = 7'b0100011,
    parameter logic [1:0] MEM_ACC_8      = 2'b00,
    parameter logic [1:0] MEM_ACC_16     = 2'b01,
    parameter logic [1:0] MEM_ACC_32     = 2'b10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [6:0]                op,
    input  logic [2:0]                funct3,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [M_WIDTH-1:0]        store_val,
    input  logic [M_WIDTH-1:0]        alu_val,
    mem_access_if.master              mem,
    output logic                      wb_en,
    output logic [6:0]                wb_op,
    output logic [2:0]                wb_funct3,
    output logic [REG_ADDR_WIDTH-1:0] wb_reg_addr,
    output logic [M_WIDTH-1:0]        wb_val,
    output logic                      busy,
    output logic [1:0]                dbg_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        byte_idx;
    logic [1:0]        last_idx;
    logic [1:0]        nxt_idx;
    logic [1:0]        size_last;
    logic              is_load;
    logic [M_WIDTH-1:0] st_val;
    logic              start_mem;
    logic              xfer;

    assign start_mem = (op == OP_LOAD) || (op == OP_STORE);
    assign xfer      = mem.mem_req && mem.mem_ack;
    assign nxt_idx   = byte_idx + 2'd1;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Index of the final byte; the reserved size code behaves as a word.
    always_comb begin
        size_last = 2'd3;
        case (funct3[1:0])
            MEM_ACC_8:  size_last = 2'd0;
            MEM_ACC_16: size_last = 2'd1;
            MEM_ACC_32: size_last = 2'd3;
            default:    size_last = 2'd3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = start_mem ? ACCESS : DONE;
            ACCESS:  if (xfer && (byte_idx == last_idx)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_wdata  <= '0;
            wb_en          <= 1'b0;
            wb_op          <= '0;
            wb_funct3      <= '0;
            wb_reg_addr    <= '0;
            wb_val         <= '0;
            byte_idx       <= '0;
            last_idx       <= '0;
            is_load        <= 1'b0;
            st_val         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        wb_op       <= op;
                        wb_funct3   <= funct3;
                        wb_reg_addr <= reg_addr;
                        if (start_mem) begin
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= (op == OP_STORE);
                            mem.mem_addr  <= addr;
                            mem.mem_wdata <= store_val[7:0];
                            st_val        <= store_val;
                            is_load       <= (op == OP_LOAD);
                            byte_idx      <= '0;
                            last_idx      <= size_last;
                            wb_val        <= '0;
                        end else begin
                            wb_val <= alu_val;
                            wb_en  <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (xfer) begin
                        if (is_load) wb_val[{byte_idx, 3'b000} +: 8] <= mem.mem_rdata;
                        if (byte_idx == last_idx) begin
                            mem.mem_req <= 1'b0;
                            mem.mem_we  <= 1'b0;
                            wb_en       <= 1'b1;
                        end else begin
                            byte_idx      <= nxt_idx;
                            mem.mem_addr  <= mem.mem_addr + ADDR_ONE;
                            mem.mem_wdata <= st_val[{nxt_idx, 3'b000} +: 8];
                        end
                    end
                end
                DONE:    wb_en <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: behavioural byte memory with configurable
// ack waits, expected result and transfer queues, directed and random instructions.
module tb_mem_access;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [6:0]  op = '0;
    logic [2:0]  funct3 = '0;
    logic [3:0]  reg_addr = '0;
    logic [31:0] addr = '0;
    logic [31:0] store_val = '0;
    logic [31:0] alu_val = '0;
    logic        wb_en;
    logic [6:0]  wb_op;
    logic [2:0]  wb_funct3;
    logic [3:0]  wb_reg_addr;
    logic [31:0] wb_val;
    logic        busy;
    logic [1:0]  dbg_state;

    mem_access_if #(.ADDR_WIDTH(32)) bus ();

    mem_access dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .funct3(funct3),
        .reg_addr(reg_addr), .addr(addr), .store_val(store_val), .alu_val(alu_val),
        .mem(bus.master),
        .wb_en(wb_en), .wb_op(wb_op), .wb_funct3(wb_funct3), .wb_reg_addr(wb_reg_addr),
        .wb_val(wb_val), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0]  mem_model [logic [31:0]];
    logic [31:0] exp_q[$];
    logic [40:0] exp_xq[$];
    logic [40:0] obs_xq[$];
    int req_cycles = 0;
    int wait_total = 0;
    int ack_wait = 0;
    int cnt = 0;
    bit rand_wait = 1'b0;
    bit ack_noise = 1'b0;
    logic [31:0] hold_addr = '0;
    logic [7:0]  hold_wdata = '0;

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (!mem_model.exists(a)) mem_model[a] = 8'($urandom_range(0, 255));
        return mem_model[a];
    endfunction

    function automatic int n_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Expected writeback value and byte transfers for one instruction.
    task automatic expect_instr(input logic [6:0] o, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sv, input logic [31:0] alu);
        logic [31:0] v;
        logic [31:0] ba;
        v = '0;
        if (o == OP_LOAD || o == OP_STORE) begin
            for (int i = 0; i < n_bytes(f3); i++) begin
                ba = a + 32'(i);
                if (o == OP_LOAD) begin
                    v = v | (32'(mem_rd(ba)) << (8 * i));
                    exp_xq.push_back({1'b0, ba, mem_rd(ba)});
                end else begin
                    exp_xq.push_back({1'b1, ba, 8'(sv >> (8 * i))});
                end
            end
        end else begin
            v = alu;
        end
        exp_q.push_back(v);
    endtask

    // ---------------- memory slave ----------------
    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst || !bus.mem_req) begin
                cnt = 0;
                bus.mem_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.mem_rdata = 8'($urandom);
            end else begin
                req_cycles++;
                if (cnt > 0) begin
                    tests_run++;
                    if (bus.mem_addr !== hold_addr || (bus.mem_we && bus.mem_wdata !== hold_wdata)) begin
                        tests_failed++;
                        $display("FAIL hold_stable: addr %h wdata %h, required %h %h",
                                 bus.mem_addr, bus.mem_wdata, hold_addr, hold_wdata);
                    end
                end
                hold_addr = bus.mem_addr;
                hold_wdata = bus.mem_wdata;
                if (cnt >= ack_wait) begin
                    bus.mem_ack = 1'b1;
                    cnt = 0;
                    if (bus.mem_we) begin
                        mem_model[bus.mem_addr] = bus.mem_wdata;
                        bus.mem_rdata = 8'($urandom);
                        obs_xq.push_back({1'b1, bus.mem_addr, bus.mem_wdata});
                    end else begin
                        bus.mem_rdata = mem_rd(bus.mem_addr);
                        obs_xq.push_back({1'b0, bus.mem_addr, bus.mem_rdata});
                    end
                    if (rand_wait) ack_wait = $urandom_range(0, 2);
                end else begin
                    bus.mem_ack = 1'b0;
                    cnt++;
                    wait_total++;
                    bus.mem_rdata = 8'($urandom);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge; pulses en for one edge and observes the wb_en pulse.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [3:0] ra,
                             input logic [31:0] a, input logic [31:0] sv, input logic [31:0] alu,
                             input int budget, input bit glitch,
                             output bit found, output int off, output logic [31:0] v,
                             output logic [13:0] fields, output logic en_after, output logic busy_after);
        op = o; funct3 = f3; reg_addr = ra; addr = a; store_val = sv; alu_val = alu;
        en = 1'b1;
        req_cycles = 0; wait_total = 0;
        found = 1'b0; off = -1; v = '0; fields = '0; en_after = 1'b0; busy_after = 1'b0;
        @(negedge clk);
        en = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (c > 0) @(negedge clk);
            en = 1'b0;
            if (wb_en) begin
                found = 1'b1; off = c; v = wb_val;
                fields = {wb_op, wb_funct3, wb_reg_addr};
                break;
            end
            if (glitch && busy) en = 1'($urandom_range(0, 1));
        end
        en = 1'b0;
        if (found) begin
            @(negedge clk);
            en_after = wb_en;
            busy_after = busy;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [99:0] outs;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        outs = {bus.mem_req, bus.mem_we, wb_en, busy, bus.mem_addr, bus.mem_wdata,
                wb_val, wb_op, wb_funct3, wb_reg_addr};
        tests_run++;
        if (outs !== '0) begin tests_failed++; $display("FAIL reset_por: outputs %h, required 0", outs); end
        rst = 1'b0;
        ack_wait = 1;
        @(negedge clk);
        op = OP_LOAD; funct3 = 3'b010; reg_addr = 4'd9; addr = 32'h40; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.mem_req !== 1'b1) begin tests_failed++; $display("FAIL reset_pre_req: mem_req %b, required 1", bus.mem_req); end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        outs = {bus.mem_req, bus.mem_we, wb_en, busy, bus.mem_addr, bus.mem_wdata,
                wb_val, wb_op, wb_funct3, wb_reg_addr};
        tests_run++;
        if (outs !== '0) begin tests_failed++; $display("FAIL reset_async: outputs %h, required 0", outs); end
        @(negedge clk);
        rst = 1'b0;
        obs_xq.delete(); exp_xq.delete(); exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_alu();
        bit found; int off; logic [31:0] v; logic [13:0] f; logic ea, ba;
        run_instr(OP_ALU, 3'b000, 4'd5, 32'h0, 32'h0, 32'h12345678, 20, 1'b0, found, off, v, f, ea, ba);
        tests_run++; if (!found || off != 0) begin tests_failed++; $display("FAIL alu_latency: found %b offset %0d, required 1 0", found, off); end
        tests_run++; if (v !== 32'h12345678) begin tests_failed++; $display("FAIL alu_val: wb_val %h, required 12345678", v); end
        tests_run++; if (f !== {OP_ALU, 3'b000, 4'd5}) begin tests_failed++; $display("FAIL alu_fields: %h, required %h", f, {OP_ALU, 3'b000, 4'd5}); end
        tests_run++; if (req_cycles != 0) begin tests_failed++; $display("FAIL alu_no_req: req cycles %0d, required 0", req_cycles); end
        tests_run++; if (ea !== 1'b0 || ba !== 1'b0) begin tests_failed++; $display("FAIL alu_pulse: wb_en %b busy %b after, required 0 0", ea, ba); end
    endtask

    task automatic test_lw();
        bit found; int off; logic [31:0] v; logic [13:0] f; logic ea, ba;
        ack_wait = 0;
        mem_model[32'h100] = 8'h78; mem_model[32'h101] = 8'h56;
        mem_model[32'h102] = 8'h34; mem_model[32'h103] = 8'h12;
        expect_instr(OP_LOAD, 3'b010, 32'h100, 32'h0, 32'h0);
        run_instr(OP_LOAD, 3'b010, 4'd3, 32'h100, 32'hDEADBEEF, 32'hCAFEF00D, 40, 1'b0, found, off, v, f, ea, ba);
        tests_run++; if (!found || off != 4) begin tests_failed++; $display("FAIL lw_latency: found %b offset %0d, required 1 4", found, off); end
        tests_run++; if (v !== exp_q.pop_front()) begin tests_failed++; $display("FAIL lw_val: wb_val %h, required 12345678", v); end
        tests_run++; if (f !== {OP_LOAD, 3'b010, 4'd3}) begin tests_failed++; $display("FAIL lw_fields: %h, required %h", f, {OP_LOAD, 3'b010, 4'd3}); end
        tests_run++; if (req_cycles != 4) begin tests_failed++; $display("FAIL lw_req_cycles: %0d, required 4", req_cycles); end
        tests_run++; if (obs_xq.size() != exp_xq.size()) begin tests_failed++; $display("FAIL lw_xfer_count: %0d, required %0d", obs_xq.size(), exp_xq.size()); end
        for (int i = 0; i < exp_xq.size() && i < obs_xq.size(); i++) begin
            tests_run++; if (obs_xq[i] !== exp_xq[i]) begin tests_failed++; $display("FAIL lw_xfer%0d: %h, required %h", i, obs_xq[i], exp_xq[i]); end
        end
        obs_xq.delete(); exp_xq.delete();
        tests_run++; if (ea !== 1'b0 || ba !== 1'b0) begin tests_failed++; $display("FAIL lw_pulse: wb_en %b busy %b after, required 0 0", ea, ba); end
    endtask

    task automatic test_lb_wait();
        bit found; int off; logic [31:0] v; logic [13:0] f; logic ea, ba;
        ack_wait = 3;
        mem_model[32'h200] = 8'h80;
        run_instr(OP_LOAD, 3'b000, 4'd7, 32'h200, 32'hFFFFFFFF, 32'h0, 40, 1'b0, found, off, v, f, ea, ba);
        tests_run++; if (!found || off != 4) begin tests_failed++; $display("FAIL lb_latency: found %b offset %0d, required 1 4", found, off); end
        tests_run++; if (v !== 32'h00000080) begin tests_failed++; $display("FAIL lb_val: wb_val %h, required 00000080", v); end
        tests_run++; if (f[6:4] !== 3'b000) begin tests_failed++; $display("FAIL lb_funct3: %b, required 000", f[6:4]); end
        tests_run++; if (req_cycles != 4 || obs_xq.size() != 1) begin tests_failed++; $display("FAIL lb_hold: req cycles %0d xfers %0d, required 4 1", req_cycles, obs_xq.size()); end
        tests_run++; if (obs_xq.size() > 0 && obs_xq[0][39:8] !== 32'h200) begin tests_failed++; $display("FAIL lb_addr: %h, required 00000200", obs_xq[0][39:8]); end
        obs_xq.delete();
        ack_wait = 0;
    endtask

    task automatic test_sh_wrap();
        bit found; int off; logic [31:0] v; logic [13:0] f; logic ea, ba;
        ack_wait = 0;
        expect_instr(OP_STORE, 3'b001, 32'hFFFFFFFF, 32'hAABBCCDD, 32'h0);
        run_instr(OP_STORE, 3'b001, 4'd0, 32'hFFFFFFFF, 32'hAABBCCDD, 32'h55555555, 40, 1'b0, found, off, v, f, ea, ba);
        tests_run++; if (!found || off != 2) begin tests_failed++; $display("FAIL sh_latency: found %b offset %0d, required 1 2", found, off); end
        tests_run++; if (v !== exp_q.pop_front()) begin tests_failed++; $display("FAIL sh_val: wb_val %h, required 0", v); end
        tests_run++; if (obs_xq.size() != 2) begin tests_failed++; $display("FAIL sh_xfer_count: %0d, required 2", obs_xq.size()); end
        for (int i = 0; i < exp_xq.size() && i < obs_xq.size(); i++) begin
            tests_run++; if (obs_xq[i] !== exp_xq[i]) begin tests_failed++; $display("FAIL sh_xfer%0d: %h, required %h", i, obs_xq[i], exp_xq[i]); end
        end
        obs_xq.delete(); exp_xq.delete();
        tests_run++; if (mem_model[32'h0] !== 8'hCC) begin tests_failed++; $display("FAIL sh_wrap_byte: mem[0] %h, required cc", mem_model[32'h0]); end
    endtask

    task automatic test_abort();
        bit found; int off; logic [31:0] v; logic [13:0] f; logic ea, ba;
        int wb_seen;
        ack_wait = 0;
        op = OP_LOAD; funct3 = 3'b010; reg_addr = 4'd2; addr = 32'h180; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int c = 0; c < 20 && obs_xq.size() < 2; c++) begin
            #1;
            if (obs_xq.size() < 2) @(negedge clk);
        end
        #1;
        tests_run++; if (obs_xq.size() != 2) begin tests_failed++; $display("FAIL abort_setup: xfers %0d, required 2", obs_xq.size()); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++; if (bus.mem_req !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL abort_req_drop: mem_req %b busy %b, required 0 0", bus.mem_req, busy); end
        @(negedge clk);
        rst = 1'b0;
        wb_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (wb_en) wb_seen++;
        end
        tests_run++; if (wb_seen != 0) begin tests_failed++; $display("FAIL abort_no_wb: wb_en cycles %0d, required 0", wb_seen); end
        obs_xq.delete(); exp_xq.delete();
        ack_wait = 1;
        expect_instr(OP_LOAD, 3'b010, 32'h300, 32'h0, 32'h0);
        run_instr(OP_LOAD, 3'b010, 4'd4, 32'h300, 32'h0, 32'h0, 40, 1'b0, found, off, v, f, ea, ba);
        tests_run++; if (!found || off != 8) begin tests_failed++; $display("FAIL abort_new_latency: found %b offset %0d, required 1 8", found, off); end
        tests_run++; if (v !== exp_q.pop_front()) begin tests_failed++; $display("FAIL abort_new_val: wb_val %h", v); end
        tests_run++; if (obs_xq.size() != 4) begin tests_failed++; $display("FAIL abort_new_count: %0d, required 4", obs_xq.size()); end
        for (int i = 0; i < exp_xq.size() && i < obs_xq.size(); i++) begin
            tests_run++; if (obs_xq[i] !== exp_xq[i]) begin tests_failed++; $display("FAIL abort_new_xfer%0d: %h, required %h", i, obs_xq[i], exp_xq[i]); end
        end
        obs_xq.delete(); exp_xq.delete();
        ack_wait = 0;
    endtask

    task automatic test_back_to_back();
        logic [6:0]  ops [4] = '{OP_ALU, OP_LOAD, OP_STORE, 7'b0110011};
        logic [2:0]  f3s [4] = '{3'b000, 3'b101, 3'b010, 3'b111};
        logic [31:0] ads [4] = '{32'h0, 32'h41, 32'h50, 32'h0};
        bit found; int off; logic [31:0] v; logic [13:0] f; logic ea, ba;
        logic [31:0] sv, alu;
        int exp_off;
        ack_wait = 0;
        for (int k = 0; k < 4; k++) begin
            sv = $urandom; alu = $urandom;
            expect_instr(ops[k], f3s[k], ads[k], sv, alu);
            exp_off = (ops[k] == OP_LOAD || ops[k] == OP_STORE) ? n_bytes(f3s[k]) : 0;
            run_instr(ops[k], f3s[k], 4'(k + 8), ads[k], sv, alu, 40, 1'b0, found, off, v, f, ea, ba);
            tests_run++; if (!found || off != exp_off) begin tests_failed++; $display("FAIL b2b%0d_latency: found %b offset %0d, required 1 %0d", k, found, off, exp_off); end
            tests_run++; if (v !== exp_q.pop_front()) begin tests_failed++; $display("FAIL b2b%0d_val: wb_val %h", k, v); end
            tests_run++; if (f !== {ops[k], f3s[k], 4'(k + 8)}) begin tests_failed++; $display("FAIL b2b%0d_fields: %h, required %h", k, f, {ops[k], f3s[k], 4'(k + 8)}); end
            tests_run++; if (obs_xq.size() != exp_xq.size()) begin tests_failed++; $display("FAIL b2b%0d_xfer_count: %0d, required %0d", k, obs_xq.size(), exp_xq.size()); end
            for (int i = 0; i < exp_xq.size() && i < obs_xq.size(); i++) begin
                tests_run++; if (obs_xq[i] !== exp_xq[i]) begin tests_failed++; $display("FAIL b2b%0d_xfer%0d: %h, required %h", k, i, obs_xq[i], exp_xq[i]); end
            end
            obs_xq.delete(); exp_xq.delete();
        end
    endtask

    task automatic test_random();
        bit found; int off; logic [31:0] v; logic [13:0] f; logic ea, ba;
        logic [6:0] o; logic [2:0] f3; logic [3:0] ra; logic [31:0] a, sv, alu;
        int exp_off;
        ack_noise = 1'b1;
        rand_wait = 1'b1;
        ack_wait = $urandom_range(0, 2);
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 2))
                0: o = OP_LOAD;
                1: o = OP_STORE;
                default: begin
                    o = 7'($urandom);
                    if (o == OP_LOAD || o == OP_STORE) o = 7'b0110011;
                end
            endcase
            f3 = 3'($urandom); ra = 4'($urandom); sv = $urandom; alu = $urandom;
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : 32'($urandom_range(0, 31));
            expect_instr(o, f3, a, sv, alu);
            run_instr(o, f3, ra, a, sv, alu, 60, 1'b1, found, off, v, f, ea, ba);
            exp_off = (o == OP_LOAD || o == OP_STORE) ? n_bytes(f3) + wait_total : 0;
            tests_run++; if (!found || off != exp_off) begin tests_failed++; $display("FAIL rnd%0d_latency: found %b offset %0d, required 1 %0d", k, found, off, exp_off); end
            tests_run++; if (v !== exp_q.pop_front()) begin tests_failed++; $display("FAIL rnd%0d_val: wb_val %h op %b f3 %b addr %h", k, v, o, f3, a); end
            tests_run++; if (f !== {o, f3, ra}) begin tests_failed++; $display("FAIL rnd%0d_fields: %h, required %h", k, f, {o, f3, ra}); end
            tests_run++; if (ea !== 1'b0 || ba !== 1'b0) begin tests_failed++; $display("FAIL rnd%0d_pulse: wb_en %b busy %b after, required 0 0", k, ea, ba); end
            tests_run++; if (obs_xq.size() != exp_xq.size()) begin tests_failed++; $display("FAIL rnd%0d_xfer_count: %0d, required %0d", k, obs_xq.size(), exp_xq.size()); end
            for (int i = 0; i < exp_xq.size() && i < obs_xq.size(); i++) begin
                tests_run++; if (obs_xq[i] !== exp_xq[i]) begin tests_failed++; $display("FAIL rnd%0d_xfer%0d: %h, required %h", k, i, obs_xq[i], exp_xq[i]); end
            end
            obs_xq.delete(); exp_xq.delete();
        end
        ack_noise = 1'b0;
        rand_wait = 1'b0;
        ack_wait = 0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_alu();
        test_lw();
        test_lb_wait();
        test_sh_wrap();
        test_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
